// File: rtl/alu_bitserial_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_bitserial_driver
// Brief    : Streams a WIDTH-bit op LSB-first into a 1-bit ALU and collects
//            the result, flagging the first bit that disagrees with a golden model.
// Revision : 1.0
// ============================================================================
module alu_bitserial_driver #(
    parameter int WIDTH    = 8,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 op,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       ready,
    output logic                       alu_s0,
    output logic                       alu_s1,
    output logic                       alu_d0,
    output logic                       alu_d1,
    input  logic                       alu_o0,
    output logic [WIDTH-1:0]           result,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(WIDTH)-1:0]   err_idx
);

    localparam int               c_cw   = $clog2(WIDTH);
    localparam logic [1:0]       c_idle = 2'd0;
    localparam logic [1:0]       c_run  = 2'd1;
    localparam logic [1:0]       c_done = 2'd2;
    localparam logic [c_cw-1:0]  c_last = c_cw'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [c_cw-1:0]  r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_err;
    logic [c_cw-1:0]  r_err_idx;
    logic             r_done;
    logic             r_ready;
    logic             r_s0;
    logic             r_s1;
    logic             r_d0;
    logic             r_d1;
    logic             w_expect;

    // r_a/r_b shift right each RUN cycle, so bit 0 is always the bit on the wire.
    always_comb begin
        w_expect = 1'b0;
        case (r_op)
            2'b00:   w_expect = r_a[0] & r_b[0];
            2'b01:   w_expect = r_a[0] | r_b[0];
            2'b10:   w_expect = r_a[0] ^ r_b[0];
            default: w_expect = ~r_a[0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_idle;
            r_cnt     <= '0;
            r_op      <= 2'b00;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
            r_s0      <= 1'b0;
            r_s1      <= 1'b0;
            r_d0      <= 1'b0;
            r_d1      <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op      <= op;
                        r_a       <= a;
                        r_b       <= b;
                        r_result  <= '0;
                        r_err     <= 1'b0;
                        r_err_idx <= '0;
                        r_cnt     <= '0;
                        r_s0      <= op[1];
                        r_s1      <= op[0];
                        r_d0      <= a[0];
                        r_d1      <= b[0];
                        r_ready   <= 1'b0;
                        r_state   <= c_run;
                    end
                end
                c_run: begin
                    r_result[r_cnt] <= alu_o0;
                    if (CHECK_EN && (alu_o0 != w_expect) && !r_err) begin
                        r_err     <= 1'b1;
                        r_err_idx <= r_cnt;
                    end
                    if (r_cnt == c_last) begin
                        r_s0    <= 1'b0;
                        r_s1    <= 1'b0;
                        r_d0    <= 1'b0;
                        r_d1    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_done;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_a   <= r_a >> 1;
                        r_b   <= r_b >> 1;
                        r_d0  <= r_a[1];
                        r_d1  <= r_b[1];
                    end
                end
                c_done: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= c_idle;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign ready   = r_ready;
    assign done    = r_done;
    assign result  = r_result;
    assign err     = r_err;
    assign err_idx = r_err_idx;
    assign alu_s0  = r_s0;
    assign alu_s1  = r_s1;
    assign alu_d0  = r_d0;
    assign alu_d1  = r_d1;

endmodule
`default_nettype wire

// File: tb/tb_alu_bitserial_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_bitserial_driver
// Brief    : Self-checking bench for alu_bitserial_driver with a fault-injecting ALU.
// Revision : 1.0
// ============================================================================
module tb_alu_bitserial_driver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         inj;

    logic         ready, s0, s1, d0, d1, o0, done, err;
    logic [W-1:0] result;
    logic [2:0]   err_idx;
    logic         nc_ready, nc_s0, nc_s1, nc_d0, nc_d1, nc_o0, nc_done, nc_err;
    logic [W-1:0] nc_result;
    logic [2:0]   nc_err_idx;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_bitserial_driver #(.WIDTH(W), .CHECK_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .alu_s0(s0), .alu_s1(s1), .alu_d0(d0), .alu_d1(d1),
        .alu_o0(o0), .result(result), .done(done), .err(err), .err_idx(err_idx)
    );

    alu_bitserial_driver #(.WIDTH(W), .CHECK_EN(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .ready(nc_ready), .alu_s0(nc_s0), .alu_s1(nc_s1), .alu_d0(nc_d0), .alu_d1(nc_d1),
        .alu_o0(nc_o0), .result(nc_result), .done(nc_done), .err(nc_err), .err_idx(nc_err_idx)
    );

    // External 1-bit ALU; inj flips its output to emulate a faulty ALU.
    function automatic logic alu_bit(input logic vs0, vs1, vd0, vd1);
        case ({vs0, vs1})
            2'b00:   return vd0 & vd1;
            2'b01:   return vd0 | vd1;
            2'b10:   return vd0 ^ vd1;
            default: return ~vd0;
        endcase
    endfunction

    assign o0    = alu_bit(s0, s1, d0, d1) ^ inj;
    assign nc_o0 = alu_bit(nc_s0, nc_s1, nc_d0, nc_d1) ^ inj;

    function automatic logic [W-1:0] model_word(input logic [1:0] mop, input logic [W-1:0] ma, mb);
        case (mop)
            2'b00:   return ma & mb;
            2'b01:   return ma | mb;
            2'b10:   return ma ^ mb;
            default: return ~ma;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full operation: accept at edge 0, RUN in cycles 1..W, done in W+1, idle in W+2.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] va, vb, mask,
                          input bit busy, input logic [W-1:0] er, input logic ee,
                          input logic [2:0] ei);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb; inj = 1'b0;
        @(negedge clk);
        start = 1'b0; op = ~o; a = ~va; b = ~vb;
        for (int i = 0; i < W; i++) begin
            if (i > 0) @(negedge clk);
            check("run_pins", {26'd0, done, ready, s0, s1, d0, d1},
                  {26'd0, 1'b0, 1'b0, o[1], o[0], va[i], vb[i]});
            inj = mask[i];
            if (busy && i == 2) begin
                start = 1'b1; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        inj = 1'b0;
        if (busy) begin
            start = 1'b1; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
        end
        check("done_ready", {30'd0, done, ready}, {30'd0, 1'b1, 1'b0});
        check("result", {24'd0, result}, {24'd0, er});
        check("err", {31'd0, err}, {31'd0, ee});
        check("err_idx", {29'd0, err_idx}, {29'd0, ei});
        check("nc_result", {24'd0, nc_result}, {24'd0, er});
        check("nc_err", {28'd0, nc_err, nc_err_idx}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("idle_after", {24'd0, done, ready, s0, s1, d0, d1, err, 1'b0},
              {24'd0, 1'b0, 1'b1, 4'b0000, ee, 1'b0});
        check("result_hold", {24'd0, result}, {24'd0, er});
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, mask, exp_res;
        logic         exp_err;
        logic [2:0]   exp_idx;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2'b00, 8'hCA, 8'h6F, 8'h00, 8'h4A, 1'b0, 3'd0};
        vecs[1] = '{2'b01, 8'hCA, 8'h6F, 8'h00, 8'hEF, 1'b0, 3'd0};
        vecs[2] = '{2'b10, 8'hCA, 8'h6F, 8'h00, 8'hA5, 1'b0, 3'd0};
        vecs[3] = '{2'b11, 8'hCA, 8'h6F, 8'h00, 8'h35, 1'b0, 3'd0};
        vecs[4] = '{2'b10, 8'hCA, 8'h6F, 8'h48, 8'hED, 1'b1, 3'd3};
        vecs[5] = '{2'b11, 8'h00, 8'hFF, 8'h80, 8'h7F, 1'b1, 3'd7};
        vecs[6] = '{2'b00, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 3'd0};

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; inj = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {19'd0, ready, done, err, err_idx, result},
              {19'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00});
        check("reset_pins", {28'd0, s0, s1, d0, d1}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++)
            run_op(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].mask, 1'b0,
                   vecs[v].exp_res, vecs[v].exp_err, vecs[v].exp_idx);

        // Starts during RUN and DONE must be dropped.
        run_op(2'b00, 8'h5A, 8'h3C, 8'h00, 1'b1, 8'h18, 1'b0, 3'd0);
        @(negedge clk);
        check("no_extra_done", {30'd0, done, ready}, {30'd0, 1'b0, 1'b1});

        // Reset in cycle 5 of a run.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 8'h3C; b = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_state", {21'd0, ready, done, err, result},
              {21'd0, 1'b1, 1'b0, 1'b0, 8'h00});
        check("rst_mid_pins", {28'd0, s0, s1, d0, d1}, 32'd0);
        @(negedge clk);
        check("rst_no_done", {31'd0, done}, 32'd0);
        run_op(2'b01, 8'h3C, 8'h81, 8'h00, 1'b0, 8'hBD, 1'b0, 3'd0);

        // start held high: accepts every W+2 cycles.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 8'h0F; b = 8'hF0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            check("b2b_done", {31'd0, done}, {31'd0, (c % 10) == 9});
            check("b2b_ready", {31'd0, ready}, {31'd0, (c % 10) == 0});
            if ((c % 10) == 9) begin
                check("b2b_result", {24'd0, result}, 32'h0000_00FF);
                check("b2b_err", {31'd0, err}, 32'd0);
            end
        end
        start = 1'b0;

        // Randomized operations against the word-level model.
        for (int r = 0; r < 40; r++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb, rm, rexp;
            logic [2:0]   ridx;
            ro = 2'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            rm = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
            rexp = model_word(ro, ra, rb) ^ rm;
            ridx = 3'd0;
            for (int k = W - 1; k >= 0; k--)
                if (rm[k]) ridx = 3'(k);
            run_op(ro, ra, rb, rm, 1'b0, rexp, rm != '0, ridx);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
